segment_demod: RTL and testbench

SEGMENT_DEMOD -- requirements
Module: segment_demod

---
 rtl/segment_demod.sv | 135 +++++++++++++
 tb/tb_segment_demod.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/segment_demod.sv
// -----------------------------------------------------------------------------
// segment_demod
//
// Recovers a frame of NBITS symbols from a stream of signed 32-bit segment
// samples. Each symbol is SEGS segments long. The first half of the segments
// is added to an accumulator and the second half is subtracted. On the last
// segment, the sign of the final sum decides the bit. A sum >= 0 gives 1, so a
// sum of exactly zero decodes as 1. Each decided bit is shifted into the LSB,
// so the first symbol of the frame ends up in the MSB.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous active-low reset
//   start       single-cycle frame request (ignored while busy)
//   seg_valid   seg_in carries a segment this cycle (only consumed in COLLECT)
//   seg_in      signed 32-bit segment sample
//   busy        high in COLLECT and DONE
//   valid       one-cycle strobe, output_bit holds a complete frame
//   output_bit  last completed frame, held until the next frame completes
//   bit_count   symbols decided so far in the current frame
//
// State    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; segment inputs ignored
// COLLECT  | consuming segments, deciding one bit per SEGS segments
// DONE     | frame published (valid high this cycle), returns to IDLE
// -----------------------------------------------------------------------------
module segment_demod #(
    parameter int SEGS  = 10,
    parameter int NBITS = 32,
    parameter int ACCW  = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             seg_valid,
    input  logic [31:0]      seg_in,
    output logic             busy,
    output logic             valid,
    output logic [NBITS-1:0] output_bit,
    output logic [5:0]       bit_count
);

    localparam int IDXW = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam logic [IDXW-1:0] HALF_IDX   = IDXW'(SEGS / 2);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(SEGS - 1);
    localparam logic [5:0]      FRAME_BITS = 6'(NBITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 state;
    logic signed [ACCW-1:0] acc;
    logic [IDXW-1:0]        seg_idx;
    logic [NBITS-1:0]       shreg;

    logic signed [ACCW-1:0] seg_ext;
    logic signed [ACCW-1:0] acc_sum;
    logic                   decided_bit;
    logic [NBITS-1:0]       shreg_next;
    logic [5:0]             bit_count_inc;

    // The final sum includes the current segment's contribution. This lets
    // the bit be decided on the same edge that consumes the last segment.
    always_comb begin
        seg_ext       = {{(ACCW-32){seg_in[31]}}, seg_in};
        acc_sum       = (seg_idx < HALF_IDX) ? (acc + seg_ext) : (acc - seg_ext);
        decided_bit   = ~acc_sum[ACCW-1];
        shreg_next    = {shreg[NBITS-2:0], decided_bit};
        bit_count_inc = bit_count + 6'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            valid      <= 1'b0;
            output_bit <= '0;
            bit_count  <= '0;
            acc        <= '0;
            seg_idx    <= '0;
            shreg      <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state     <= COLLECT;
                        busy      <= 1'b1;
                        acc       <= '0;
                        seg_idx   <= '0;
                        bit_count <= '0;
                        shreg     <= '0;
                    end
                end

                COLLECT: begin
                    if (seg_valid) begin
                        if (seg_idx == LAST_IDX) begin
                            acc       <= '0;
                            seg_idx   <= '0;
                            shreg     <= shreg_next;
                            bit_count <= bit_count_inc;
                            // Publish on the entry edge into DONE so valid
                            // follows the final segment by one cycle.
                            if (bit_count_inc == FRAME_BITS) begin
                                state      <= DONE;
                                output_bit <= shreg_next;
                                valid      <= 1'b1;
                            end
                        end else begin
                            acc     <= acc_sum;
                            seg_idx <= seg_idx + 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_demod.sv
module tb_segment_demod;

    logic        clk;
    logic        reset;
    logic        start;
    logic        seg_valid;
    logic [31:0] seg_in;
    logic        busy;
    logic        valid;
    logic [31:0] output_bit;
    logic [5:0]  bit_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_seg_cyc = 0;
    int n_pushed = 0;
    int n_pulses = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_exp = '0;
    logic [31:0] exp_q[$];

    segment_demod dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seg_valid (seg_valid),
        .seg_in    (seg_in),
        .busy      (busy),
        .valid     (valid),
        .output_bit(output_bit),
        .bit_count (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pops one expected frame per valid strobe.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_valid) check("valid_one_cycle", {31'd0, valid}, 32'd0);
            if (valid) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got output_bit %h expected no frame", output_bit);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("frame_data", output_bit, e);
                    check("frame_bit_count", {26'd0, bit_count}, 32'd32);
                    check("valid_latency", cyc, last_seg_cyc);
                end
            end
            prev_valid = valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    function automatic logic [31:0] seg_val(input int mode, input logic [31:0] data,
                                            input int sym, input int seg);
        logic pos;
        logic b;
        logic [31:0] v;
        pos = (seg < 5);
        b   = data[31-sym];
        case (mode)
            0:       v = (((sym % 2) == 0) == pos) ? 32'd1000 : -32'd1000;
            1:       v = pos ? 32'h7FFF_FFFF : 32'h8000_0000;
            2:       v = 32'd0;
            3:       v = (seg == 0) ? (b ? 32'd5 : -32'd5) : ((seg == 7) ? 32'd3 : 32'd0);
            default: v = (seg == 9) ? 32'd101 : 32'd100;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int mode, input logic [31:0] data, input logic [31:0] exp_val,
                             input bit stall, input bit poke);
        int wait_cnt;
        if (poke) begin
            // Segments offered in IDLE must be ignored.
            for (int i = 0; i < 4; i++) begin
                seg_valid = 1'b1;
                seg_in    = 32'h8000_0000;
                step();
            end
            check("idle_busy", {31'd0, busy}, 32'd0);
        end
        start     = 1'b1;
        seg_valid = poke;
        seg_in    = 32'h8000_0000;
        step();
        start     = 1'b0;
        seg_valid = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        exp_q.push_back(exp_val);
        n_pushed++;
        for (int sym = 0; sym < 32; sym++) begin
            if (sym == 16) begin
                check("mid_bit_count", {26'd0, bit_count}, 32'd16);
                check("output_held", output_bit, last_exp);
            end
            for (int seg = 0; seg < 10; seg++) begin
                if (stall) begin
                    seg_valid = 1'b0;
                    seg_in    = 32'h8000_0000;
                    step();
                end
                seg_valid = 1'b1;
                seg_in    = seg_val(mode, data, sym, seg);
                start     = (poke && sym == 5 && seg == 0);
                step();
                start        = 1'b0;
                last_seg_cyc = cyc;
            end
        end
        seg_valid = 1'b0;
        wait_cnt  = 0;
        while (busy && wait_cnt < 10) begin
            step();
            wait_cnt++;
        end
        check("frame_returns_idle", {31'd0, busy}, 32'd0);
        step();
        check("pulse_count", n_pulses, n_pushed);
        check("output_after_frame", output_bit, exp_val);
        last_exp = exp_val;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        seg_valid = 1'b0;
        seg_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_output", output_bit, 32'd0);
        check("reset_bit_count", {26'd0, bit_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_frame(0, 32'd0, 32'hAAAA_AAAA, 1'b0, 1'b0);   // alternating symbols
        run_frame(0, 32'd0, 32'hAAAA_AAAA, 1'b1, 1'b0);   // stalls
        run_frame(1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);   // extremes
        run_frame(2, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);   // all zero, tie -> 1
        run_frame(4, 32'd0, 32'h0000_0000, 1'b0, 1'b0);   // sum -1 -> 0
        run_frame(3, 32'h3C5A_9601, 32'h3C5A_9601, 1'b0, 1'b0);
        run_frame(0, 32'd0, 32'hAAAA_AAAA, 1'b0, 1'b1);   // ignored inputs

        // Reset mid-frame after 100 segments.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            seg_valid = 1'b1;
            seg_in    = seg_val(0, 32'd0, i / 10, i % 10);
            step();
        end
        seg_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_bit_count", {26'd0, bit_count}, 32'd0);
        check("midreset_output", output_bit, 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        last_exp = 32'd0;
        run_frame(3, 32'h8123_4567, 32'h8123_4567, 1'b0, 1'b0);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("total_pulses", n_pulses, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
